// File: rtl/fft8_pkg.sv
// Shared constants and types for the 8-point FFT front end.
package fft8_pkg;

  localparam int DW    = 32;
  localparam int FFT_N = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/fft8_bank.sv
// One frame of FFT_N samples: single lane write port, whole-frame read port.
module fft8_bank
  import fft8_pkg::*;
#(
  parameter int DW = fft8_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [2:0]          idx,
  input  logic [DW-1:0]       wdata,
  output logic [FFT_N*DW-1:0] rdata
);

  logic [FFT_N-1:0][DW-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Packed layout puts lane k at bits [k*DW +: DW].
  assign rdata = mem;

endmodule

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel loader: ping-pongs two sample banks into 8-lane frames for the FFT.
module fft8_frame_loader
  import fft8_pkg::*;
#(
  parameter int DW = fft8_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [8*DW-1:0]     m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                err_short,
  output logic [15:0]         frame_cnt
);

  bank_state_t bst_q [2];
  bank_state_t bst_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic              accept, deliver, short_last;
  logic              we0, we1;
  logic [8*DW-1:0]   rdata0, rdata1;

  fft8_bank #(.DW(DW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we0),
    .idx   (wr_idx_q),
    .wdata (s_data),
    .rdata (rdata0)
  );

  fft8_bank #(.DW(DW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .idx   (wr_idx_q),
    .wdata (s_data),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst_q[0]  <= EMPTY;
      bst_q[1]  <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bst_q[0]  <= bst_d[0];
      bst_q[1]  <= bst_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Accept only targets a non-FULL write bank and deliver only a FULL read
  // bank, so the two updates below never touch the same bank.
  always_comb begin
    bst_d[0]  = bst_q[0];
    bst_d[1]  = bst_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    cnt_d     = cnt_q;
    err_d     = short_last;

    if (deliver) begin
      bst_d[rd_bank_q] = EMPTY;
      rd_bank_d        = ~rd_bank_q;
      cnt_d            = cnt_q + 16'd1;
    end

    if (accept) begin
      if (short_last) begin
        bst_d[wr_bank_q] = EMPTY;
        wr_idx_d         = '0;
      end else if (wr_idx_q == 3'd7) begin
        bst_d[wr_bank_q] = FULL;
        wr_bank_d        = ~wr_bank_q;
        wr_idx_d         = '0;
      end else begin
        bst_d[wr_bank_q] = FILLING;
        wr_idx_d         = wr_idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    s_ready    = !((bst_q[0] == FULL) && (bst_q[1] == FULL));
    m_valid    = (bst_q[rd_bank_q] == FULL);
    m_data     = rd_bank_q ? rdata1 : rdata0;
    accept     = s_valid & s_ready;
    deliver    = m_valid & m_ready;
    short_last = accept & s_last & (wr_idx_q != 3'd7);
    we0        = accept & ~short_last & ~wr_bank_q;
    we1        = accept & ~short_last & wr_bank_q;
  end

  assign err_short = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed bench for fft8_frame_loader with hand-computed expectations.
module tb_fft8_frame_loader;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [8*DW-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            err_short;
  logic [15:0]     frame_cnt;

  int checks   = 0;
  int failures = 0;
  int sr_drops = 0;

  fft8_frame_loader #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_short (err_short),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input int k);
    return m_data[k*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int n;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n > 0) sr_drops++;
    if (n == 50) chk("send_timeout", 32'd0, 32'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) chk(tag, lane(k), base + DW'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(|m_data), 32'd0);
    chk("rst_err", 32'(err_short), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic frame 1..8 with m_ready high
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
    chk("basic_valid", 32'(m_valid), 32'd1);
    chk_frame("basic_lane", 32'd1);
    chk("basic_cnt0", 32'(frame_cnt), 32'd0);
    tick();
    chk("basic_valid_off", 32'(m_valid), 32'd0);
    chk("basic_cnt1", 32'(frame_cnt), 32'd1);

    // Back-pressure: two frames fill both banks
    m_ready = 1'b0;
    for (int i = 100; i <= 115; i++) begin
      send(DW'(i), 1'b0);
      if (i == 107) chk("bp_valid_a", 32'(m_valid), 32'd1);
      if (i == 114) chk("bp_ready_114", 32'(s_ready), 32'd1);
    end
    chk("bp_ready_low", 32'(s_ready), 32'd0);
    tick(); tick();
    chk("bp_ready_hold", 32'(s_ready), 32'd0);
    chk_frame("bp_hold_lane", 32'd100);
    m_ready = 1'b1;
    tick();
    chk("bp_ready_back", 32'(s_ready), 32'd1);
    chk("bp_valid_b", 32'(m_valid), 32'd1);
    chk_frame("bp_b_lane", 32'd108);
    chk("bp_cnt2", 32'(frame_cnt), 32'd2);
    tick();
    chk("bp_valid_off", 32'(m_valid), 32'd0);
    chk("bp_cnt3", 32'(frame_cnt), 32'd3);
    for (int i = 116; i <= 123; i++) send(DW'(i), 1'b0);
    chk_frame("bp_c_lane", 32'd116);
    tick();
    chk("bp_cnt4", 32'(frame_cnt), 32'd4);

    // Continuous streaming, 80 samples
    sr_drops = 0;
    for (int i = 0; i < 80; i++) send(DW'(1000 + i), 1'b0);
    chk("stream_no_stall", 32'(sr_drops), 32'd0);
    chk("stream_valid", 32'(m_valid), 32'd1);
    chk_frame("stream_last_lane", 32'd1072);
    tick();
    chk("stream_cnt", 32'(frame_cnt), 32'd14);

    // Short frame then a clean frame
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    chk("short_err", 32'(err_short), 32'd1);
    chk("short_no_valid", 32'(m_valid), 32'd0);
    tick();
    chk("short_err_off", 32'(err_short), 32'd0);
    chk("short_cnt", 32'(frame_cnt), 32'd14);
    for (int i = 10; i <= 17; i++) send(DW'(i), 1'b0);
    chk("after_short_valid", 32'(m_valid), 32'd1);
    chk_frame("after_short_lane", 32'd10);
    tick();
    chk("after_short_cnt", 32'(frame_cnt), 32'd15);
    chk("after_short_err", 32'(err_short), 32'd0);

    // Completion and deliver on the same edge
    m_ready = 1'b0;
    for (int i = 20; i <= 27; i++) send(DW'(i), 1'b0);
    for (int i = 30; i <= 36; i++) send(DW'(i), 1'b0);
    chk_frame("sim_hold_lane", 32'd20);
    m_ready = 1'b1;
    send(32'd37, 1'b0);
    chk("sim_valid", 32'(m_valid), 32'd1);
    chk_frame("sim_new_lane", 32'd30);
    chk("sim_cnt", 32'(frame_cnt), 32'd16);
    tick();
    chk("sim_valid_off", 32'(m_valid), 32'd0);
    chk("sim_cnt2", 32'(frame_cnt), 32'd17);

    // Asynchronous reset with a stalled frame and a partial frame
    m_ready = 1'b0;
    for (int i = 40; i <= 47; i++) send(DW'(i), 1'b0);
    for (int i = 50; i <= 54; i++) send(DW'(i), 1'b0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_data", 32'(|m_data), 32'd0);
    chk("mid_rst_err", 32'(err_short), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_err", 32'(err_short), 32'd0);
    m_ready = 1'b1;
    for (int i = -8; i <= -1; i++) send(DW'(i), 1'b0);
    chk("neg_valid", 32'(m_valid), 32'd1);
    chk("neg_lane0", lane(0), 32'hFFFF_FFF8);
    chk("neg_lane3", lane(3), 32'hFFFF_FFFB);
    chk("neg_lane7", lane(7), 32'hFFFF_FFFF);
    tick();
    chk("neg_cnt", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
